// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the fifo_level FIFO family.
package fifo_pkg;

  typedef enum logic {RD_FWFT, RD_STD} rd_mode_e;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/fifo_level_if.sv
// Producer/consumer-facing signal bundle of fifo_level; the FIFO itself uses the slave side.
interface fifo_level_if #(
  parameter int ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, w_data, rd, err_clr,
    input  r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, w_data, rd, err_clr,
    output r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_level_ctrl.sv
// Pointer, occupancy and flag control for fifo_level; all status flags decode from count_q only.
module fifo_level_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] w_ptr,
  output logic [ADDR_WIDTH-1:0] r_ptr,
  output logic                  wr_acc,
  output logic                  rd_acc,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_level_ctrl: AF_THRESH %0d outside 1..%0d", AF_THRESH, DEPTH);
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_level_ctrl: AE_THRESH %0d outside 0..%0d", AE_THRESH, DEPTH - 1);
  end

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr && !wr_acc) ovf_d = 1'b1;
    if (rd && !rd_acc) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign w_ptr     = w_ptr_q;
  assign r_ptr     = r_ptr_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy count, threshold flags, sticky errors and selectable read path.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int       ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int       DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int       AF_THRESH  = 6,
  parameter int       AE_THRESH  = 2,
  parameter rd_mode_e READ_MODE  = RD_FWFT
) (
  input logic         clk,
  input logic         reset,
  fifo_level_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic                  wr_acc, rd_acc, empty;

  fifo_level_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .wr          (bus.wr),
    .rd          (bus.rd),
    .err_clr     (bus.err_clr),
    .w_ptr       (w_ptr),
    .r_ptr       (r_ptr),
    .wr_acc      (wr_acc),
    .rd_acc      (rd_acc),
    .count       (bus.count),
    .full        (bus.full),
    .empty       (empty),
    .almost_full (bus.almost_full),
    .almost_empty(bus.almost_empty),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow)
  );

  assign bus.empty = empty;

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[w_ptr] <= bus.w_data;
  end

  if (READ_MODE == RD_STD) begin : g_std
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_valid_q, r_valid_d;

    always_comb begin
      r_data_d  = r_data_q;
      r_valid_d = 1'b0;
      if (rd_acc) begin
        r_data_d  = mem_q[r_ptr];
        r_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_data_q  <= r_data_d;
        r_valid_q <= r_valid_d;
      end
    end

    assign bus.r_data  = r_data_q;
    assign bus.r_valid = r_valid_q;
  end else begin : g_fwft
    logic unused_rd_acc;
    assign unused_rd_acc = rd_acc;
    // Gate to zero while empty so the output is defined from reset despite unreset storage.
    assign bus.r_data  = empty ? '0 : mem_q[r_ptr];
    assign bus.r_valid = ~empty;
  end
endmodule
